muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
// - Iterative RV32M multiply/divide unit sequencer beside the single-cycle ALU in EX.
// - Takes an M-extension op from decode via a start/ready handshake and latches operands.
// - Runs a one-bit-per-cycle shift-add multiply or restoring divide, then applies sign fix-up.
// - Holds the pipeline through stall_o and returns a registered result with a done_o pulse.
// PARAMETERS
// - XLEN    32   operand/result width; iteration count equals XLEN
// - CNT_W   6    iteration counter width; must satisfy 2**CNT_W > XLEN
// PORTS
// - clk       in   1      system clock, rising edge
// - rst       in   1      asynchronous, active-high reset
// - start_i   in   1      request valid; accepted only when ready_o=1
// - funct3_i  in   3      RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                         100 DIV, 101 DIVU, 110 REM, 111 REMU
// - a_i       in   XLEN   rs1 operand
// - b_i       in   XLEN   rs2 operand
// - flush_i   in   1      abort in-flight op (branch mispredict/trap)
// - ready_o   out  1      1 only in IDLE
// - busy_o    out  1      1 in PREP, RUN, FIX
// - stall_o   out  1      = busy_o | (start_i & ready_o); freezes IF/ID/EX
// - done_o    out  1      one-cycle pulse, result_o valid
// - result_o  out  XLEN   registered result; held until next accepted op
// BEHAVIOUR
// - Reset (async): state=IDLE, counter=0, result_o=0, done_o=0, busy_o=0, ready_o=1.
// - Accept: start_i & ready_o at edge t0 latches funct3_i, a_i, b_i; later input changes ignored.
// - FSM:
//   - IDLE -> PREP on accept.
//   - PREP (1 cycle): for signed ops, take operand magnitudes and record the result sign;
//     clear the accumulator; counter=0.
//   - RUN (XLEN cycles): one iteration per cycle; counter increments; -> FIX when counter==XLEN-1.
//   - FIX (1 cycle): apply sign correction and select the result half or part -> DONE.
//   - DONE (1 cycle): done_o=1, result_o updated on entry -> IDLE.
// - Latency: done_o is high in cycle t0+XLEN+3, which is 35 cycles for XLEN=32.
//   ready_o returns to 1 in the following cycle.
// - Multiply: 2*XLEN-bit product.
//   - MUL returns the low half.
//   - MULH, MULHSU and MULHU return the high half.
//   - Signedness per op: MULHSU treats a as signed and b as unsigned.
// - Divide: restoring algorithm on magnitudes.
//   - Quotient sign = sign(a)^sign(b); remainder takes the sign of a.
// - Boundary rules, enforced in FIX:
//   - b==0: DIV/DIVU -> all ones; REM/REMU -> original a.
//   - DIV of -2^(XLEN-1) by -1 -> -2^(XLEN-1); REM -> 0.
// - start_i while not ready_o: ignored, no queuing.
// - flush_i: the state returns to IDLE at the next edge from any state.
//   - No done_o is produced and result_o is unchanged.
//   - flush_i with start_i in IDLE: the request is not accepted.
// - A new accept is possible in the cycle after DONE. There is no back-to-back accept in DONE.
// CONFIGURATION
// - MULDIV_EARLY_OUT_EN defined:
//   - A divide with b==0, or a multiply with a==0 or b==0, goes PREP -> FIX and skips RUN.
//   - done_o is then high at t0+3.
// - MULDIV_EARLY_OUT_EN undefined: every op takes the full XLEN+3 latency.
// TESTING
// - MUL a=7, b=-3 -> done_o at t0+35, result_o=0xFFFFFFEB; ready_o low for t0+1..t0+35.
// - MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000.
// - DIV a=-20, b=3 -> 0xFFFFFFFA (-6); REM same operands -> 0xFFFFFFFE (-2).
// - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
//   DIVU a=5, b=0 -> 0xFFFFFFFF; REMU a=5, b=0 -> 5.
//   With MULDIV_EARLY_OUT_EN, the b==0 case has done_o at t0+3.
// - Flush at t0+10 of a DIV -> IDLE at t0+11, no done_o, result_o keeps its prior value.
//   A new MUL 2*3 then returns 6.
// - Assert rst mid-RUN -> immediate IDLE, result_o=0, done_o=0.
//   A start_i during busy_o is ignored and the in-flight result is unaffected.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiply, restoring divide, sign fix-up.
// Define MULDIV_EARLY_OUT_EN to skip the iteration phase for trivial (zero-operand) ops.
module muldiv_sequencer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [2:0] {StIdle, StPrep, StRun, StFix, StDone} state_e;

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_q, b_q, bm_q, hi_q, lo_q, result_q;
  logic              neg_a_q, neg_b_q, done_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              a_sgn, b_sgn, neg_a, neg_b, early;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum, div_shift;
  logic              div_ok;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo, rem, fix_res;
  logic              b_zero, ovf;

  always_comb begin
    a_sgn = op_q[2] ? ~op_q[0] : (op_q[1:0] != 2'b11);
    b_sgn = op_q[2] ? ~op_q[0] : ~op_q[1];
    neg_a = a_sgn & a_q[XLEN-1];
    neg_b = b_sgn & b_q[XLEN-1];
    mag_a = neg_a ? -a_q : a_q;
    mag_b = neg_b ? -b_q : b_q;
  end

`ifdef MULDIV_EARLY_OUT_EN
  assign early = op_q[2] ? (b_q == '0) : ((a_q == '0) || (b_q == '0));
`else
  assign early = 1'b0;
`endif

  // One iteration of each algorithm; hi_q is the accumulator / partial remainder.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, bm_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_ok    = div_shift >= {1'b0, bm_q};
    div_rem   = div_shift[XLEN-1:0] - bm_q;
  end

  always_comb begin
    prod    = {hi_q, lo_q};
    prod_s  = (neg_a_q ^ neg_b_q) ? -prod : prod;
    quo     = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
    rem     = neg_a_q ? -hi_q : hi_q;
    b_zero  = (b_q == '0);
    ovf     = ~op_q[0] && (a_q == MinNeg) && (b_q == '1);
    fix_res = '0;
    if (!op_q[2]) begin
      fix_res = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end else if (b_zero) begin
      fix_res = op_q[1] ? a_q : '1;
    end else if (ovf) begin
      fix_res = op_q[1] ? '0 : MinNeg;
    end else begin
      fix_res = op_q[1] ? rem : quo;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      bm_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (flush_i) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_i) begin
              op_q    <= funct3_i;
              a_q     <= a_i;
              b_q     <= b_i;
              state_q <= StPrep;
            end
          end
          StPrep: begin
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
            bm_q    <= mag_b;
            lo_q    <= early ? '0 : mag_a;
            hi_q    <= '0;
            cnt_q   <= '0;
            state_q <= early ? StFix : StRun;
          end
          StRun: begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (op_q[2]) begin
              hi_q <= div_ok ? div_rem : div_shift[XLEN-1:0];
              lo_q <= {lo_q[XLEN-2:0], div_ok};
            end else begin
              hi_q <= mul_sum[XLEN:1];
              lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
            end
            if (cnt_q == CNT_W'(XLEN - 1)) state_q <= StFix;
          end
          StFix: begin
            result_q <= fix_res;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end
          StDone:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign ready_o  = (state_q == StIdle);
  assign busy_o   = (state_q == StPrep) || (state_q == StRun) || (state_q == StFix);
  assign stall_o  = busy_o | (start_i & ready_o);
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer: results, latency, flush, reset, boundaries.
module tb_muldiv_sequencer;

  logic        clk, rst, start_i, flush_i;
  logic [2:0]  funct3_i;
  logic [31:0] a_i, b_i, result_o;
  logic        ready_o, busy_o, stall_o, done_o;

  int vectors = 0;
  int miscompares = 0;

  localparam int LatFull = 35;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int LatZero = 3;
`else
  localparam int LatZero = 35;
`endif

  muldiv_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .funct3_i (funct3_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .flush_i  (flush_i),
    .ready_o  (ready_o),
    .busy_o   (busy_o),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble inputs after accept, optionally poke start_i while busy.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input bit poke);
    int lat;
    bit rdy_bad;
    @(negedge clk);
    chk({tag, " ready"}, 32'(ready_o), 32'd1);
    start_i = 1'b1; funct3_i = f; a_i = a; b_i = b;
    #1 chk({tag, " stall"}, 32'(stall_o), 32'd1);
    @(posedge clk);
    #1 start_i = 1'b0; funct3_i = ~f; a_i = ~a; b_i = ~b;
    lat = 0;
    rdy_bad = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (done_o) begin
        lat = n;
        break;
      end
      if (ready_o) rdy_bad = 1'b1;
      start_i = poke && (n >= 4) && (n <= 6);
    end
    start_i = 1'b0;
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " ready low while busy"}, 32'(rdy_bad), 32'd0);
    chk({tag, " result"}, result_o, exp);
    @(negedge clk);
    chk({tag, " ready after done"}, 32'(ready_o), 32'd1);
    chk({tag, " done pulse"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    bit saw_done;
    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; funct3_i = 3'd0; a_i = '0; b_i = '0;
    #1;
    chk("reset ready", 32'(ready_o), 32'd1);
    chk("reset busy", 32'(busy_o), 32'd0);
    chk("reset done", 32'(done_o), 32'd0);
    chk("reset result", result_o, 32'd0);
    chk("reset stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op("MUL 7*-3",        3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LatFull, 1'b0);
    run_op("MULHU -1*-1",     3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LatFull, 1'b0);
    run_op("MULH -1*-1",      3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, LatFull, 1'b0);
    run_op("MULHSU -1*2",     3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, LatFull, 1'b0);
    run_op("DIV -20/3",       3'b100, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, LatFull, 1'b0);
    run_op("REM -20/3",       3'b110, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, LatFull, 1'b0);
    run_op("DIV ovf",         3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LatFull, 1'b0);
    run_op("REM ovf",         3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, LatFull, 1'b0);
    run_op("DIVU 5/0",        3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, LatZero, 1'b0);
    run_op("REMU 5/0",        3'b111, 32'd5,        32'd0,        32'd5,        LatZero, 1'b0);
    run_op("DIV -7/0",        3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, LatZero, 1'b0);
    run_op("REM -7/0",        3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, LatZero, 1'b0);
    run_op("DIVU 100/7",      3'b101, 32'd100,      32'd7,        32'd14,       LatFull, 1'b0);
    run_op("REMU 100/7",      3'b111, 32'd100,      32'd7,        32'd2,        LatFull, 1'b0);
    run_op("MUL 0*5",         3'b000, 32'd0,        32'd5,        32'd0,        LatZero, 1'b0);
    run_op("MUL poke busy",   3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LatFull, 1'b1);

    // Flush a DIV in cycle t0+10; result must keep the previous op's value.
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'b100; a_i = 32'hFFFFFFEC; b_i = 32'd3;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    chk("flush ready", 32'(ready_o), 32'd1);
    chk("flush busy", 32'(busy_o), 32'd0);
    chk("flush result kept", result_o, 32'hFFFFFFEB);
    saw_done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done_o) saw_done = 1'b1;
    end
    chk("flush no done", 32'(saw_done), 32'd0);
    run_op("MUL 2*3 after flush", 3'b000, 32'd2, 32'd3, 32'd6, LatFull, 1'b0);

    // Flush together with start in idle: request dropped.
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1; funct3_i = 3'b101; a_i = 32'd9; b_i = 32'd3;
    @(posedge clk);
    #1 start_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    chk("flush+start ready", 32'(ready_o), 32'd1);
    chk("flush+start busy", 32'(busy_o), 32'd0);
    chk("flush+start result", result_o, 32'd6);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'b100; a_i = 32'hFFFFFFEC; b_i = 32'd3;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre-reset busy", 32'(busy_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid reset ready", 32'(ready_o), 32'd1);
    chk("mid reset busy", 32'(busy_o), 32'd0);
    chk("mid reset done", 32'(done_o), 32'd0);
    chk("mid reset result", result_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("MULHU after reset", 3'b011, 32'h80000000, 32'd4, 32'd2, LatFull, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
